// File: rtl/gpu_param_instruction_fifo.sv
// First-word-fall-through instruction FIFO between the APB command decoder and the rasteriser.
// Any depth (wrap is explicit), programmable almost-full margin, sync flush, sticky errors.
module gpu_param_instruction_fifo #(
  parameter int DATA_WIDTH = 79,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  push_acc;
  logic                  pop_acc;

  // Status comes only from the registered count, never from push_i/pop_i.
  assign empty_o       = (count == '0);
  assign full_o        = (count == FULL_LVL);
  assign almost_full_o = (count >= AF_LVL);
  assign count_o       = count;
  assign rd_data_o     = empty_o ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign pop_acc  = pop_i & ~empty_o;
  assign push_acc = push_i & (~full_o | pop_i);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= next_ptr(wr_ptr);
      if (pop_acc)  rd_ptr <= next_ptr(rd_ptr);
      if (push_acc && !pop_acc)      count <= count + CW'(1);
      else if (pop_acc && !push_acc) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !flush_i) mem[wr_ptr] <= wr_data_i;
  end

  // Set wins over clear; flush leaves the flags alone.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_i && full_o && !pop_i) overflow_o <= 1'b1;
      else if (err_clr_i)             overflow_o <= 1'b0;
      if (pop_i && empty_o)           underflow_o <= 1'b1;
      else if (err_clr_i)             underflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_param_instruction_fifo.sv
// Directed bench: vector table on an 8-deep FIFO, hand sequences for wrap (5-deep) and reset.
module tb_gpu_param_instruction_fifo;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // 8-deep, default parameters
  logic        a_flush = 0, a_push = 0, a_pop = 0, a_clr = 0;
  logic [78:0] a_wdata = '0, a_rdata;
  logic        a_empty, a_full, a_af, a_ovf, a_unf;
  logic [3:0]  a_count;

  // 5-deep, AF_MARGIN=2
  logic        b_flush = 0, b_push = 0, b_pop = 0, b_clr = 0;
  logic [15:0] b_wdata = '0, b_rdata;
  logic        b_empty, b_full, b_af, b_ovf, b_unf;
  logic [2:0]  b_count;

  gpu_param_instruction_fifo u_a (
    .clk(clk), .n_rst(n_rst), .flush_i(a_flush), .push_i(a_push), .wr_data_i(a_wdata),
    .pop_i(a_pop), .err_clr_i(a_clr), .rd_data_o(a_rdata), .empty_o(a_empty),
    .full_o(a_full), .almost_full_o(a_af), .count_o(a_count),
    .overflow_o(a_ovf), .underflow_o(a_unf));

  gpu_param_instruction_fifo #(.DATA_WIDTH(16), .DEPTH(5), .AF_MARGIN(2)) u_b (
    .clk(clk), .n_rst(n_rst), .flush_i(b_flush), .push_i(b_push), .wr_data_i(b_wdata),
    .pop_i(b_pop), .err_clr_i(b_clr), .rd_data_o(b_rdata), .empty_o(b_empty),
    .full_o(b_full), .almost_full_o(b_af), .count_o(b_count),
    .overflow_o(b_ovf), .underflow_o(b_unf));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int idx, input logic [78:0] act,
                       input logic [78:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        push, pop, flush, clr;
    logic [78:0] data;
    int          cnt;
    logic [78:0] rd;
    logic        ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input logic q, input logic f, input logic c,
                     input int d, input int cnt, input int rd, input logic ovf,
                     input logic unf);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f; v.clr = c; v.data = 79'(d);
    v.cnt = cnt; v.rd = 79'(rd); v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  initial begin
    // 1: fill 0x1..0x8, drain in order
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, k, k, 1, 0, 0);
    for (int j = 1; j <= 8; j++) add(0, 1, 0, 0, 0, 8 - j, (j < 8) ? j + 1 : 0, 0, 0);
    // 2: full, push+pop of 0xA; 0xA leaves last
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 'h10 + k, k, 'h11, 0, 0);
    add(1, 1, 0, 0, 'hA, 8, 'h12, 0, 0);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 0, 0, 0, 8 - j, (j <= 6) ? 'h12 + j : ((j == 7) ? 'hA : 0), 0, 0);
    // 3: empty push+pop -> underflow, word kept; clear
    add(1, 1, 0, 0, 5, 1, 5, 0, 1);
    add(0, 0, 0, 1, 0, 1, 5, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // 4: push while full -> overflow, word dropped
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 'h20 + k, k, 'h21, 0, 0);
    add(1, 0, 0, 0, 'hFF, 8, 'h21, 1, 0);
    for (int j = 1; j <= 8; j++) add(0, 1, 0, 0, 0, 8 - j, (j < 8) ? 'h21 + j : 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // 6: flush with 4 entries and a concurrent push
    for (int k = 1; k <= 4; k++) add(1, 0, 0, 0, 'h30 + k, k, 'h31, 0, 0);
    add(1, 0, 1, 0, 'h99, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 'h41, 1, 'h41, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);

    n_rst = 1'b0;
    #12;
    check("rst_count", 0, 79'(a_count), 79'd0);
    check("rst_empty", 0, 79'(a_empty), 79'd1);
    check("rst_full", 0, 79'(a_full), 79'd0);
    check("rst_af", 0, 79'(a_af), 79'd0);
    check("rst_rdata", 0, a_rdata, 79'd0);
    check("rst_ovf_unf", 0, 79'({a_ovf, a_unf}), 79'd0);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_push = vecs[i].push; a_pop = vecs[i].pop; a_flush = vecs[i].flush;
      a_clr = vecs[i].clr; a_wdata = vecs[i].data;
      @(posedge clk);
      #1;
      check("count", i, 79'(a_count), 79'(vecs[i].cnt));
      check("empty", i, 79'(a_empty), 79'(vecs[i].cnt == 0));
      check("full", i, 79'(a_full), 79'(vecs[i].cnt == 8));
      check("almost_full", i, 79'(a_af), 79'(vecs[i].cnt >= 7));
      check("rd_data", i, a_rdata, vecs[i].rd);
      check("overflow", i, 79'(a_ovf), 79'(vecs[i].ovf));
      check("underflow", i, 79'(a_unf), 79'(vecs[i].unf));
    end
    @(negedge clk);
    a_push = 0; a_pop = 0; a_flush = 0; a_clr = 0;

    // 5: 5-deep, 13 pushes crossing the wrap point, almost_full at 3
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b_push = 1; b_pop = 0; b_wdata = 16'(k);
      @(posedge clk);
      #1;
      check("b_count", k, 79'(b_count), 79'(k));
      check("b_af", k, 79'(b_af), 79'(k >= 3));
      check("b_head", k, 79'(b_rdata), 79'd1);
    end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      b_push = 1; b_pop = 1; b_wdata = 16'(4 + i);
      @(posedge clk);
      #1;
      check("b_wrap_count", i, 79'(b_count), 79'd4);
      check("b_wrap_head", i, 79'(b_rdata), 79'(1 + i));
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      b_push = 0; b_pop = 1;
      @(posedge clk);
      #1;
      check("b_drain_count", j, 79'(b_count), 79'(4 - j));
      check("b_drain_head", j, 79'(b_rdata), (j < 4) ? 79'(10 + j) : 79'd0);
    end
    check("b_errors", 0, 79'({b_ovf, b_unf}), 79'd0);
    @(negedge clk);
    b_pop = 0;

    // 6b: reset mid-burst clears everything without waiting for a clock
    @(negedge clk);
    a_pop = 1;
    @(negedge clk);
    a_pop = 0; a_push = 1; a_wdata = 79'h51;
    @(negedge clk);
    a_wdata = 79'h52;
    @(negedge clk);
    check("pre_rst_count", 0, 79'(a_count), 79'd2);
    check("pre_rst_unf", 0, 79'(a_unf), 79'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_count", 0, 79'(a_count), 79'd0);
    check("midrst_empty", 0, 79'(a_empty), 79'd1);
    check("midrst_rdata", 0, a_rdata, 79'd0);
    check("midrst_unf", 0, 79'(a_unf), 79'd0);
    check("midrst_b_empty", 0, 79'(b_empty), 79'd1);
    a_push = 0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_count", 0, 79'(a_count), 79'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
